// File: rtl/pipe_control.sv
`default_nettype none
// ============================================================================
// Module      : pipe_control
// Description : Pipelined MIPS control unit. Decodes the ID instruction into
//               a 10-bit control word, carries word and destination register
//               through EX/MEM/WB, handles load-use stalls, multi-cycle MUL
//               holds in EX and squashes illegal instructions to bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_control #(
    parameter int MUL_CYCLES = 3,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instructionIn,
    input  logic             instrValid,
    output logic             fetchStall,
    output logic [9:0]       exCtrlOut,
    output logic [9:0]       memCtrlOut,
    output logic [9:0]       wbCtrlOut,
    output logic [REG_W-1:0] exDest,
    output logic [REG_W-1:0] memDest,
    output logic [REG_W-1:0] wbDest,
    output logic             mulBusy,
    output logic             illegalOut
);

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_RTYPE = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h32;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    // Control word layout: valid, regWrite, memToReg, memRead, memWrite,
    // aluSrc, regDst, aluOp[2:0]
    localparam logic [9:0] CW_RTYPE = 10'b11_0000_1000;
    localparam logic [9:0] CW_LW    = 10'b11_1101_0000;
    localparam logic [9:0] CW_SW    = 10'b10_0011_0000;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    // Instruction fields
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             unused_shamt;

    assign opcode       = instructionIn[31:26];
    assign funct        = instructionIn[5:0];
    assign rs           = REG_W'(instructionIn[25:21]);
    assign rt           = REG_W'(instructionIn[20:16]);
    assign rd           = REG_W'(instructionIn[15:11]);
    assign unused_shamt = ^instructionIn[10:6];

    // Stage registers
    logic [9:0]       exCtrl_q,  exCtrl_d;
    logic [9:0]       memCtrl_q, memCtrl_d;
    logic [9:0]       wbCtrl_q,  wbCtrl_d;
    logic [REG_W-1:0] exDest_q,  exDest_d;
    logic [REG_W-1:0] memDest_q, memDest_d;
    logic [REG_W-1:0] wbDest_q,  wbDest_d;
    logic [CNT_W-1:0] mulCnt_q,  mulCnt_d;
    logic             illegal_q, illegal_d;

    // ID decode results
    logic [9:0]       idWord;
    logic [REG_W-1:0] idDest;
    logic             idUsesRs;
    logic             idUsesRt;
    logic             idIllegal;
    logic             idIsMul;

    logic             exIsLoad;
    logic             loadUse;
    logic             mulHold;

    // Decode the ID instruction into a control word, destination and sources
    always_comb begin
        idWord    = '0;
        idDest    = '0;
        idUsesRs  = 1'b0;
        idUsesRt  = 1'b0;
        idIllegal = 1'b0;
        idIsMul   = 1'b0;
        if (instrValid) begin
            case (opcode)
                OP_NOP: begin
                    idWord = '0;
                end
                OP_RTYPE: begin
                    idWord   = CW_RTYPE;
                    idDest   = rd;
                    idUsesRs = 1'b1;
                    idUsesRt = 1'b1;
                    case (funct)
                        FN_ADD: idWord[2:0] = ALU_ADD;
                        FN_SUB: idWord[2:0] = ALU_SUB;
                        FN_AND: idWord[2:0] = ALU_AND;
                        FN_OR:  idWord[2:0] = ALU_OR;
                        FN_MUL: begin
                            idWord[2:0] = ALU_MUL;
                            idIsMul     = 1'b1;
                        end
                        default: begin
                            // Unknown funct: squash to a bubble with no sources
                            idWord    = '0;
                            idDest    = '0;
                            idUsesRs  = 1'b0;
                            idUsesRt  = 1'b0;
                            idIllegal = 1'b1;
                        end
                    endcase
                end
                OP_LW: begin
                    idWord   = CW_LW;
                    idDest   = rt;
                    idUsesRs = 1'b1;
                end
                OP_SW: begin
                    idWord   = CW_SW;
                    idUsesRs = 1'b1;
                    idUsesRt = 1'b1;
                end
                default: begin
                    idIllegal = 1'b1;
                end
            endcase
            // Writes to register 0 are discarded
            if (idDest == '0) begin
                idWord[8] = 1'b0;
            end
        end
    end

    // A valid load in EX blocks any ID instruction reading its destination
    assign exIsLoad = exCtrl_q[9] & exCtrl_q[6];
    assign loadUse  = exIsLoad && (exDest_q != '0) &&
                      ((idUsesRs && (rs == exDest_q)) ||
                       (idUsesRt && (rt == exDest_q)));
    assign mulHold  = (mulCnt_q != '0);

    assign fetchStall = mulHold | loadUse;

    // Next-state selection: MUL hold, then load-use bubble, then normal advance
    always_comb begin
        exCtrl_d  = exCtrl_q;
        exDest_d  = exDest_q;
        illegal_d = 1'b0;
        mulCnt_d  = '0;
        memCtrl_d = exCtrl_q;
        memDest_d = exDest_q;
        wbCtrl_d  = memCtrl_q;
        wbDest_d  = memDest_q;
        if (mulHold) begin
            memCtrl_d = '0;
            memDest_d = '0;
            mulCnt_d  = mulCnt_q - CNT_W'(1);
        end else if (loadUse) begin
            exCtrl_d = '0;
            exDest_d = '0;
        end else begin
            exCtrl_d  = idWord;
            exDest_d  = idDest;
            illegal_d = idIllegal;
            mulCnt_d  = idIsMul ? MUL_LOAD : '0;
        end
    end

    // Stage and hold-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exCtrl_q  <= '0;
            memCtrl_q <= '0;
            wbCtrl_q  <= '0;
            exDest_q  <= '0;
            memDest_q <= '0;
            wbDest_q  <= '0;
            mulCnt_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            exCtrl_q  <= exCtrl_d;
            memCtrl_q <= memCtrl_d;
            wbCtrl_q  <= wbCtrl_d;
            exDest_q  <= exDest_d;
            memDest_q <= memDest_d;
            wbDest_q  <= wbDest_d;
            mulCnt_q  <= mulCnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign exCtrlOut  = exCtrl_q;
    assign memCtrlOut = memCtrl_q;
    assign wbCtrlOut  = wbCtrl_q;
    assign exDest     = exDest_q;
    assign memDest    = memDest_q;
    assign wbDest     = wbDest_q;
    assign mulBusy    = mulHold;
    assign illegalOut = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_control
// Description : Self-checking bench for pipe_control: directed scenarios plus
//               randomized instruction streams against a stage-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_control;

    localparam int MUL_CYCLES = 3;
    localparam int REG_W      = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instructionIn;
    logic             instrValid;
    logic             fetchStall;
    logic [9:0]       exCtrlOut;
    logic [9:0]       memCtrlOut;
    logic [9:0]       wbCtrlOut;
    logic [REG_W-1:0] exDest;
    logic [REG_W-1:0] memDest;
    logic [REG_W-1:0] wbDest;
    logic             mulBusy;
    logic             illegalOut;

    pipe_control #(
        .MUL_CYCLES(MUL_CYCLES),
        .REG_W     (REG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instructionIn(instructionIn),
        .instrValid   (instrValid),
        .fetchStall   (fetchStall),
        .exCtrlOut    (exCtrlOut),
        .memCtrlOut   (memCtrlOut),
        .wbCtrlOut    (wbCtrlOut),
        .exDest       (exDest),
        .memDest      (memDest),
        .wbDest       (wbDest),
        .mulBusy      (mulBusy),
        .illegalOut   (illegalOut)
    );

    always #5 clk = ~clk;

    // One pipeline slot in the reference model; a source of 0 means "none"
    typedef struct packed {
        logic [9:0] w;
        logic [4:0] d;
        logic       ill;
        logic       isMul;
        logic       isLoad;
        logic [4:0] s1;
        logic [4:0] s2;
    } stg_t;

    stg_t m_ex, m_mem, m_wb;
    int   m_age;        // edges the current EX occupant has spent in EX
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction semantics straight from the encoding rules
    function automatic stg_t decode(input logic [31:0] ins, input logic v);
        stg_t r;
        int   op, fn, alu;
        bit   rw, m2r, mr, mw, asrc, rdst, ok;
        r  = '0;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        alu = 0; rw = 0; m2r = 0; mr = 0; mw = 0; asrc = 0; rdst = 0; ok = 1;
        if (!v || op == 0) begin
            ok = 0;
        end else if (op == 2) begin
            case (fn)
                'h20: alu = 0;
                'h22: alu = 1;
                'h32: begin alu = 2; r.isMul = 1'b1; end
                'h24: alu = 3;
                'h25: alu = 4;
                default: begin ok = 0; r.ill = 1'b1; end
            endcase
            if (ok) begin
                rw = 1; rdst = 1;
                r.d = ins[15:11]; r.s1 = ins[25:21]; r.s2 = ins[20:16];
            end
        end else if (op == 3) begin
            rw = 1; m2r = 1; mr = 1; asrc = 1;
            r.d = ins[20:16]; r.s1 = ins[25:21]; r.isLoad = 1'b1;
        end else if (op == 4) begin
            mw = 1; asrc = 1;
            r.s1 = ins[25:21]; r.s2 = ins[20:16];
        end else begin
            ok = 0; r.ill = 1'b1;
        end
        if (ok) begin
            r.w = 10'(512 + ((rw && r.d != 0) ? 256 : 0) + (m2r ? 128 : 0) + (mr ? 64 : 0)
                      + (mw ? 32 : 0) + (asrc ? 16 : 0) + (rdst ? 8 : 0) + alu);
        end
        return r;
    endfunction

    function automatic bit m_hold();
        return m_ex.isMul && (m_age < MUL_CYCLES);
    endfunction

    function automatic bit m_loaduse(input stg_t id);
        return m_ex.isLoad && (m_ex.d != 0) && ((id.s1 == m_ex.d) || (id.s2 == m_ex.d));
    endfunction

    function automatic bit m_stall();
        return m_hold() || m_loaduse(decode(instructionIn, instrValid));
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_age = 1;
    endtask

    task automatic model_edge();
        stg_t id;
        bit   lu;
        id = decode(instructionIn, instrValid);
        if (m_hold()) begin
            m_wb  = m_mem;
            m_mem = '0;
            m_age++;
        end else begin
            lu    = m_loaduse(id);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = lu ? stg_t'('0) : id;
            m_age = 1;
        end
    endtask

    task automatic check_outputs();
        check("exCtrl",  32'(exCtrlOut),  32'(m_ex.w));
        check("memCtrl", 32'(memCtrlOut), 32'(m_mem.w));
        check("wbCtrl",  32'(wbCtrlOut),  32'(m_wb.w));
        check("exDest",  32'(exDest),     32'(m_ex.d));
        check("memDest", 32'(memDest),    32'(m_mem.d));
        check("wbDest",  32'(wbDest),     32'(m_wb.d));
        check("mulBusy", 32'(mulBusy),    32'(m_hold()));
        check("illegal", 32'(illegalOut), 32'(m_ex.ill));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex"},   32'(exCtrlOut),  32'h0);
        check({tag, "_mem"},  32'(memCtrlOut), 32'h0);
        check({tag, "_wb"},   32'(wbCtrlOut),  32'h0);
        check({tag, "_dst"},  32'({exDest, memDest, wbDest}), 32'h0);
        check({tag, "_busy"}, 32'(mulBusy),    32'h0);
        check({tag, "_ill"},  32'(illegalOut), 32'h0);
    endtask

    // One clock: check stall on the falling edge, step the model, check outputs
    task automatic cycle(output bit stalled, output logic dut_stall);
        bit exp_stall;
        @(negedge clk);
        exp_stall = m_stall();
        dut_stall = fetchStall;
        check("fetchStall", 32'(fetchStall), 32'(exp_stall));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        stalled = exp_stall;
    endtask

    // Present an instruction until it is accepted (bounded)
    task automatic issue(input logic [31:0] ins);
        bit   st;
        logic ds;
        instructionIn = ins;
        instrValid    = 1'b1;
        st = 1'b1;
        for (int k = 0; k < 20 && st; k++) begin
            cycle(st, ds);
        end
        if (st) check("issue_timeout", 32'h1, 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        int         sel;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        sel = $urandom_range(0, 9);
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        op  = 6'd2;
        fn  = 6'h20;
        case (sel)
            0: op = 6'd0;
            1, 2: begin
                case ($urandom_range(0, 3))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    default: fn = 6'h25;
                endcase
            end
            3, 4, 5: op = 6'd3;
            6: op = 6'd4;
            7: op = ($urandom_range(0, 1) == 0) ? 6'd1 : 6'($urandom_range(5, 63));
            8: fn = 6'h32;
            default: fn = 6'($urandom);
        endcase
        return {op, rs, rt, rd, 5'($urandom), fn};
    endfunction

    bit   st;
    logic ds;

    initial begin
        rst           = 1'b1;
        instructionIn = 32'h0;
        instrValid    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // ADD r9,r8,r2 flows EX -> MEM -> WB
        issue(32'h09024820);
        check("add_ex",   32'(exCtrlOut), 32'h308);
        check("add_dest", 32'(exDest),    32'd9);
        issue(32'h0);
        check("add_mem",  32'(memCtrlOut), 32'h308);
        issue(32'h0);
        check("add_wb",   32'(wbCtrlOut),  32'h308);

        // LW r8 then dependent ADD: one stall cycle with a bubble
        issue(32'h0C680004);
        check("lw_ex",   32'(exCtrlOut), 32'h3D0);
        check("lw_dest", 32'(exDest),    32'd8);
        instructionIn = 32'h09024820;
        cycle(st, ds);
        check("lu_stall",  32'(ds),        32'h1);
        check("lu_bubble", 32'(exCtrlOut), 32'h0);
        cycle(st, ds);
        check("lu_release", 32'(ds),        32'h0);
        check("lu_add_ex",  32'(exCtrlOut), 32'h308);

        // MUL r10,r1,r2 holds EX for MUL_CYCLES cycles
        issue(32'h08225032);
        check("mul_ex0",   32'(exCtrlOut), 32'h30A);
        check("mul_busy0", 32'(mulBusy),   32'h1);
        instructionIn = 32'h0;
        cycle(st, ds);
        check("mul_stall1", 32'(ds),         32'h1);
        check("mul_ex1",    32'(exCtrlOut),  32'h30A);
        check("mul_mem1",   32'(memCtrlOut), 32'h0);
        cycle(st, ds);
        check("mul_stall2", 32'(ds),         32'h1);
        check("mul_ex2",    32'(exCtrlOut),  32'h30A);
        check("mul_mem2",   32'(memCtrlOut), 32'h0);
        check("mul_busy2",  32'(mulBusy),    32'h0);
        cycle(st, ds);
        check("mul_stall3", 32'(ds),         32'h0);
        check("mul_mem3",   32'(memCtrlOut), 32'h30A);

        // LW r5 then SW r5,8(r1): one stall, then the store
        issue(32'h0C050000);
        instructionIn = 32'h10250008;
        cycle(st, ds);
        check("sw_stall", 32'(ds), 32'h1);
        cycle(st, ds);
        check("sw_ex",   32'(exCtrlOut), 32'h230);
        check("sw_dest", 32'(exDest),    32'h0);

        // Illegal opcode, illegal funct, then NOP
        issue(32'hFC000000);
        check("ill_op_ex",  32'(exCtrlOut),  32'h0);
        check("ill_op",     32'(illegalOut), 32'h1);
        issue(32'h09024821);
        check("ill_fn_ex",  32'(exCtrlOut),  32'h0);
        check("ill_fn",     32'(illegalOut), 32'h1);
        issue(32'h0);
        check("nop_ill",    32'(illegalOut), 32'h0);

        // Asynchronous reset with MUL in EX and counter at 1
        issue(32'h08225032);
        instructionIn = 32'h0;
        cycle(st, ds);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midmul_rst");
        model_reset();
        instructionIn = 32'h09024820;
        instrValid    = 1'b1;
        rst = 1'b0;
        cycle(st, ds);
        check("rst_stall",  32'(ds),        32'h0);
        check("rst_add_ex", 32'(exCtrlOut), 32'h308);

        // Randomized stream, with occasional asynchronous reset pulses
        for (int i = 0; i < 800; i++) begin
            instructionIn = rand_instr();
            instrValid    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                check_all_zero("rand_rst");
                model_reset();
                rst = 1'b0;
            end
            cycle(st, ds);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
